// File: rtl/rd53_pkg.sv
// Shared RD53 emulator definitions: TTC frame geometry, sync pattern and
// the word aligner's state encoding.
package rd53_pkg;

  localparam int unsigned      TTC_FRAME_W      = 16;
  localparam logic [15:0]      TTC_SYNC_PATTERN = 16'h817E;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } ttc_align_state_t;

endpackage

// File: rtl/ttc_word_aligner_if.sv
// Serial TTC input and aligned-frame output bundle of the word aligner.
interface ttc_word_aligner_if;
  import rd53_pkg::*;

  logic                   ttc_data;
  logic [TTC_FRAME_W-1:0] word_o;
  logic                   word_valid;
  logic                   word_is_sync;
  logic                   locked;
  logic [3:0]             lock_phase;
  logic [7:0]             unlock_count;

  modport master (
    output ttc_data,
    input  word_o, word_valid, word_is_sync, locked, lock_phase, unlock_count
  );

  modport slave (
    input  ttc_data,
    output word_o, word_valid, word_is_sync, locked, lock_phase, unlock_count
  );

endinterface

// File: rtl/ttc_sync_detect.sv
// Serial-to-parallel window, free-running bit-phase counter and sync-pattern
// comparator feeding the aligner FSM.
module ttc_sync_detect
  import rd53_pkg::*;
(
  input  logic                   clk160,
  input  logic                   rst,
  input  logic                   ttc_data_i,
  output logic [TTC_FRAME_W-1:0] window_o,
  output logic [3:0]             phase_o,
  output logic                   match_o
);

  logic [TTC_FRAME_W-1:0] window_q;
  logic [3:0]             phase_q;

  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      window_q <= '0;
      phase_q  <= '0;
    end else begin
      window_q <= {window_q[TTC_FRAME_W-2:0], ttc_data_i};
      phase_q  <= phase_q + 4'd1;
    end
  end

  assign window_o = window_q;
  assign phase_o  = phase_q;
  assign match_o  = (window_q == TTC_SYNC_PATTERN);

endmodule

// File: rtl/ttc_word_aligner.sv
// Hunts for the TTC sync pattern, locks onto its bit phase after LOCK_COUNT
// consecutive in-phase syncs, then emits one aligned frame every 16 cycles.
module ttc_word_aligner
  import rd53_pkg::*;
#(
  parameter int unsigned LOCK_COUNT   = 32,
  parameter int unsigned SYNC_TIMEOUT = 0
)
(
  input  logic               clk160,
  input  logic               rst,
  ttc_word_aligner_if.slave  bus
);

  localparam logic [7:0] LOCK_CNT_C = 8'(LOCK_COUNT);
  localparam logic [9:0] TIMEOUT_C  = 10'(SYNC_TIMEOUT);

  logic [TTC_FRAME_W-1:0] window;
  logic [3:0]             phase;
  logic                   match;

  ttc_align_state_t       state_q, state_d;
  logic [3:0]             cand_phase_q, cand_phase_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [9:0]             miss_q, miss_d;
  logic [TTC_FRAME_W-1:0] word_q, word_d;
  logic                   word_valid_q, word_valid_d;
  logic                   word_is_sync_q, word_is_sync_d;
  logic                   locked_q, locked_d;
  logic [3:0]             lock_phase_q, lock_phase_d;
  logic [7:0]             unlock_count_q, unlock_count_d;

  ttc_sync_detect u_detect (
    .clk160     (clk160),
    .rst        (rst),
    .ttc_data_i (bus.ttc_data),
    .window_o   (window),
    .phase_o    (phase),
    .match_o    (match)
  );

  always_comb begin
    state_d        = state_q;
    cand_phase_d   = cand_phase_q;
    cnt_d          = cnt_q;
    miss_d         = miss_q;
    word_d         = word_q;
    word_valid_d   = 1'b0;
    word_is_sync_d = 1'b0;
    locked_d       = locked_q;
    lock_phase_d   = lock_phase_q;
    unlock_count_d = unlock_count_q;

    unique case (state_q)
      SEARCH: begin
        if (match) begin
          if (cnt_q != '0 && phase == cand_phase_q) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            cand_phase_d = phase;
            cnt_d        = 8'd1;
          end
          // Either branch leaves the candidate phase equal to the current phase.
          if (cnt_d == LOCK_CNT_C) begin
            state_d        = LOCKED;
            locked_d       = 1'b1;
            lock_phase_d   = phase;
            miss_d         = '0;
            word_d         = window;
            word_valid_d   = 1'b1;
            word_is_sync_d = 1'b1;
          end
        end else if (phase == cand_phase_q && cnt_q != '0) begin
          cnt_d = '0;
        end
      end

      LOCKED: begin
        if (phase == lock_phase_q) begin
          word_d         = window;
          word_valid_d   = 1'b1;
          word_is_sync_d = match;
          if (match) begin
            miss_d = '0;
          end else if (miss_q != '1) begin
            miss_d = miss_q + 10'd1;
          end
          if (TIMEOUT_C != '0 && !match && miss_d == TIMEOUT_C) begin
            state_d  = SEARCH;
            locked_d = 1'b0;
            cnt_d    = '0;
            if (unlock_count_q != 8'hFF) begin
              unlock_count_d = unlock_count_q + 8'd1;
            end
          end
        end
      end

      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      state_q        <= SEARCH;
      cand_phase_q   <= '0;
      cnt_q          <= '0;
      miss_q         <= '0;
      word_q         <= '0;
      word_valid_q   <= 1'b0;
      word_is_sync_q <= 1'b0;
      locked_q       <= 1'b0;
      lock_phase_q   <= '0;
      unlock_count_q <= '0;
    end else begin
      state_q        <= state_d;
      cand_phase_q   <= cand_phase_d;
      cnt_q          <= cnt_d;
      miss_q         <= miss_d;
      word_q         <= word_d;
      word_valid_q   <= word_valid_d;
      word_is_sync_q <= word_is_sync_d;
      locked_q       <= locked_d;
      lock_phase_q   <= lock_phase_d;
      unlock_count_q <= unlock_count_d;
    end
  end

  assign bus.word_o       = word_q;
  assign bus.word_valid   = word_valid_q;
  assign bus.word_is_sync = word_is_sync_q;
  assign bus.locked       = locked_q;
  assign bus.lock_phase   = lock_phase_q;
  assign bus.unlock_count = unlock_count_q;

endmodule

// File: tb/tb_ttc_word_aligner.sv
// Directed bench for ttc_word_aligner: two instances share the serial stream,
// one with the sync timeout disabled and one with SYNC_TIMEOUT = 4.
module tb_ttc_word_aligner;
  import rd53_pkg::*;

  logic clk160 = 1'b0;
  logic rst    = 1'b1;
  logic din    = 1'b0;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int lock_edge = -1;
  int vcnt = 0;

  logic [15:0] sync_w = 16'h817E;

  always #5 clk160 = ~clk160;

  ttc_word_aligner_if if0 ();
  ttc_word_aligner_if if1 ();
  assign if0.ttc_data = din;
  assign if1.ttc_data = din;

  ttc_word_aligner #(.LOCK_COUNT(32), .SYNC_TIMEOUT(0)) u_dut0 (
    .clk160 (clk160), .rst (rst), .bus (if0)
  );
  ttc_word_aligner #(.LOCK_COUNT(32), .SYNC_TIMEOUT(4)) u_dut1 (
    .clk160 (clk160), .rst (rst), .bus (if1)
  );

  // Edges are numbered from 1 after reset release; outputs sampled 1 ns after.
  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk160);
    #1;
    edge_n++;
    if (if0.word_valid) vcnt++;
    if (lock_edge < 0 && if0.locked) lock_edge = edge_n;
  endtask

  task automatic send_frame(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    din = 1'b0;
    repeat (8) @(posedge clk160);
    #1;
    rst = 1'b0;
    edge_n = 0;
    lock_edge = -1;
    vcnt = 0;
  endtask

  task automatic test_reset();
    int vseen;
    vseen = 0;
    rst = 1'b1;
    din = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk160);
      #1;
      if (c > 0 && (if0.word_valid || if1.word_valid)) vseen++;
    end
    total++; if (vseen !== 0) begin bad++; $display("FAIL reset_valid_seen: got %0d want 0", vseen); end
    total++; if (if0.word_o !== 16'h0) begin bad++; $display("FAIL reset_word: got %h want 0000", if0.word_o); end
    total++; if (if0.word_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", if0.word_valid); end
    total++; if (if0.word_is_sync !== 1'b0) begin bad++; $display("FAIL reset_is_sync: got %b want 0", if0.word_is_sync); end
    total++; if (if0.locked !== 1'b0 || if1.locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b/%b want 0/0", if0.locked, if1.locked); end
    total++; if (if0.lock_phase !== 4'h0) begin bad++; $display("FAIL reset_lock_phase: got %0d want 0", if0.lock_phase); end
    total++; if (if1.unlock_count !== 8'h0) begin bad++; $display("FAIL reset_unlock_count: got %0d want 0", if1.unlock_count); end
    $display("reset: outputs idle after 8 cycles");
    rst = 1'b0;
    edge_n = 0;
    lock_edge = -1;
    vcnt = 0;
  endtask

  task automatic test_lock();
    int nvalid;
    repeat (32) send_frame(sync_w);
    total++; if (vcnt !== 0) begin bad++; $display("FAIL lock_search_valid: got %0d strobes want 0", vcnt); end
    total++; if (lock_edge !== -1) begin bad++; $display("FAIL lock_early: got edge %0d want none", lock_edge); end
    nvalid = 0;
    for (int j = 0; j < 32; j++) begin
      send_bit(sync_w[15 - (j % 16)]);
      if (j == 0) begin
        total++; if (lock_edge !== 513) begin bad++; $display("FAIL lock_latency: got edge %0d want 513", lock_edge); end
        total++; if (if0.lock_phase !== 4'd0) begin bad++; $display("FAIL lock_phase: got %0d want 0", if0.lock_phase); end
        total++; if (if0.word_o !== 16'h817E) begin bad++; $display("FAIL lock_word: got %h want 817e", if0.word_o); end
        total++; if (if0.word_is_sync !== 1'b1) begin bad++; $display("FAIL lock_is_sync: got %b want 1", if0.word_is_sync); end
      end
      if (if0.word_valid !== (j % 16 == 0)) nvalid++;
    end
    total++; if (nvalid !== 0) begin bad++; $display("FAIL lock_spacing: got %0d misplaced strobes want 0", nvalid); end
    total++; if (if0.word_is_sync !== 1'b0 && if0.word_valid === 1'b0) begin bad++; $display("FAIL lock_is_sync_idle: got %b want 0", if0.word_is_sync); end
    $display("lock: locked at edge %0d phase %0d", lock_edge, if0.lock_phase);
  endtask

  task automatic test_data();
    logic [15:0] w;
    logic [15:0] exp_w;
    for (int n = 0; n < 7; n++) begin
      w = (n < 6) ? 16'hF0F0 + 16'(n) : sync_w;
      exp_w = (n == 0) ? sync_w : 16'hF0F0 + 16'(n - 1);
      for (int i = 0; i < 16; i++) begin
        send_bit(w[15 - i]);
        if (i == 0) begin
          total++; if (if0.word_valid !== 1'b1) begin bad++; $display("FAIL data_valid[%0d]: got %b want 1", n, if0.word_valid); end
          total++; if (if0.word_o !== exp_w) begin bad++; $display("FAIL data_word[%0d]: got %h want %h", n, if0.word_o, exp_w); end
          total++; if (if0.word_is_sync !== (n == 0)) begin bad++; $display("FAIL data_is_sync[%0d]: got %b want %b", n, if0.word_is_sync, n == 0); end
          total++; if (if0.locked !== 1'b1) begin bad++; $display("FAIL data_locked[%0d]: got %b want 1", n, if0.locked); end
          $display("data: frame %0d word=%h sync=%b", n, if0.word_o, if0.word_is_sync);
        end else if (i == 7) begin
          total++; if (if0.word_valid !== 1'b0) begin bad++; $display("FAIL data_gap[%0d]: got %b want 0", n, if0.word_valid); end
          total++; if (if0.word_o !== exp_w) begin bad++; $display("FAIL data_hold[%0d]: got %h want %h", n, if0.word_o, exp_w); end
        end
      end
    end
  endtask

  task automatic test_broken_run();
    apply_reset();
    repeat (20) send_frame(sync_w);
    send_frame(16'h0000);
    repeat (33) send_frame(sync_w);
    total++; if (lock_edge !== 849) begin bad++; $display("FAIL broken_latency: got edge %0d want 849", lock_edge); end
    total++; if (if0.lock_phase !== 4'd0) begin bad++; $display("FAIL broken_phase: got %0d want 0", if0.lock_phase); end
    $display("broken_run: locked at edge %0d", lock_edge);
  endtask

  task automatic test_bit_slip();
    apply_reset();
    repeat (31) send_frame(sync_w);
    send_bit(1'b0);
    repeat (33) send_frame(sync_w);
    total++; if (lock_edge !== 1010) begin bad++; $display("FAIL slip_latency: got edge %0d want 1010", lock_edge); end
    total++; if (if0.lock_phase !== 4'd1) begin bad++; $display("FAIL slip_phase0: got %0d want 1", if0.lock_phase); end
    total++; if (if1.lock_phase !== 4'd1) begin bad++; $display("FAIL slip_phase1: got %0d want 1", if1.lock_phase); end
    $display("bit_slip: locked at edge %0d phase %0d", lock_edge, if0.lock_phase);
  endtask

  task automatic test_timeout_reset();
    logic [15:0] w;
    apply_reset();
    repeat (33) send_frame(sync_w);
    for (int m = 0; m < 5; m++) begin
      w = (m < 4) ? 16'h1234 + 16'(m) : sync_w;
      for (int i = 0; i < 16; i++) begin
        send_bit(w[15 - i]);
        if (i == 0 && m > 0) begin
          total++; if (if1.word_valid !== 1'b1) begin bad++; $display("FAIL tmo_valid[%0d]: got %b want 1", m, if1.word_valid); end
          total++; if (if1.word_o !== 16'h1234 + 16'(m - 1)) begin bad++; $display("FAIL tmo_word[%0d]: got %h want %h", m, if1.word_o, 16'h1234 + 16'(m - 1)); end
          total++; if (if1.locked !== (m < 4)) begin bad++; $display("FAIL tmo_locked[%0d]: got %b want %b", m, if1.locked, m < 4); end
          total++; if (if1.unlock_count !== ((m == 4) ? 8'd1 : 8'd0)) begin bad++; $display("FAIL tmo_unlock_count[%0d]: got %0d want %0d", m, if1.unlock_count, m == 4); end
          $display("timeout: miss frame %0d locked=%b unlocks=%0d", m, if1.locked, if1.unlock_count);
        end
      end
    end
    repeat (5) send_bit(1'b1);
    total++; if (if0.locked !== 1'b1) begin bad++; $display("FAIL tmo_no_timeout_locked: got %b want 1", if0.locked); end
    total++; if (if1.word_o !== 16'h1237) begin bad++; $display("FAIL tmo_word_hold: got %h want 1237", if1.word_o); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (if0.locked !== 1'b0) begin bad++; $display("FAIL async_locked: got %b want 0", if0.locked); end
    total++; if (if0.word_o !== 16'h0 || if1.word_o !== 16'h0) begin bad++; $display("FAIL async_word: got %h/%h want 0000", if0.word_o, if1.word_o); end
    total++; if (if1.unlock_count !== 8'h0) begin bad++; $display("FAIL async_unlock_count: got %0d want 0", if1.unlock_count); end
    total++; if (if0.word_valid !== 1'b0 || if0.word_is_sync !== 1'b0) begin bad++; $display("FAIL async_valid: got %b/%b want 0/0", if0.word_valid, if0.word_is_sync); end
    $display("async_reset: outputs cleared mid-frame");
    repeat (2) @(posedge clk160);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_data();
    test_broken_run();
    test_bit_slip();
    test_timeout_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
